exception_unit: RTL and testbench
=================================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Module SHALL use one clock; reset is synchronous and active-high; clock port named clk, reset port named reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 irq  input  1  external interrupt request, level-sensitive, asynchronous to instruction flow.
REQ-005 boundary  input  1  main controller is in instruction-fetch state (instruction boundary) this cycle.
REQ-006 undef  input  1  decode stage flags undefined opcode this cycle.
REQ-007 pc_i  input  32  PC of the instruction currently held by the main controller.
REQ-008 ErrorTargetWrite  output  1  write enable for the downstream error-target register.
REQ-009 ErrorTarget_o  output  5  register index to receive saved return address; constant 5'd26 ($k0) when written.
REQ-010 epc_o  output  32  return address written to ErrorTarget_o register.
REQ-011 exc_pc_write  output  1  forces PC load of handler address.
REQ-012 exc_pc_o  output  32  handler entry address.
REQ-013 stall_o  output  1  holds main controller while exception entry runs.
REQ-014 cause_o  output  2  latched cause: 00 none, 01 irq, 10 undef.
REQ-015 exc_count_o  output  8  number of exceptions taken, saturating.

Function
REQ-016 Kernel mode SHALL be defined as pc_i[31]==1; irq masked in kernel mode.
REQ-017 Pending latch irq_pend SHALL set on any cycle irq==1, clear only in the cycle the irq exception enters SAVE.
REQ-018 FSM states IDLE, SAVE, JUMP; IDLE->SAVE on trigger, SAVE->JUMP unconditionally, JUMP->IDLE unconditionally.
REQ-019 Undef trigger: undef==1 and pc_i[31]==0 in IDLE; cause 10, epc = pc_i + 4, handler 32'h8000_0008.
REQ-020 Irq trigger: boundary==1, irq_pend==1, pc_i[31]==0, no undef trigger, in IDLE; cause 01, epc = pc_i, handler 32'h8000_0004.
REQ-021 Simultaneous undef and irq trigger: undef SHALL win; irq_pend stays set and is taken at a later boundary.
REQ-022 Undef with pc_i[31]==1 SHALL be ignored (no state change, counter unchanged).
REQ-023 SAVE: ErrorTargetWrite=1, ErrorTarget_o=26, epc_o=latched epc, stall_o=1, for exactly one cycle.
REQ-024 JUMP: exc_pc_write=1, exc_pc_o=latched handler, stall_o=1, for exactly one cycle.
REQ-025 Outside SAVE/JUMP, ErrorTargetWrite, exc_pc_write, stall_o SHALL be 0; ErrorTarget_o, epc_o, exc_pc_o SHALL be 0.
REQ-026 Triggers arriving in SAVE or JUMP SHALL be ignored except irq, which sets irq_pend.
REQ-027 Latency: trigger in cycle N -> ErrorTargetWrite in N+1, exc_pc_write in N+2, IDLE in N+3.
REQ-028 epc arithmetic 32-bit modulo; pc_i=32'h7FFF_FFFC undef gives epc 32'h8000_0000.
REQ-029 exc_count_o SHALL increment on each IDLE->SAVE transition, saturate at 8'hFF.
REQ-030 cause_o SHALL hold last taken cause until next exception.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, irq_pend=0, cause_o=0, exc_count_o=0, latched epc/handler=0, all outputs 0.
REQ-032 Reset asserted in SAVE or JUMP SHALL abort the entry; no further write/PC-load pulses after reset edge.
REQ-033 Reset SHALL take priority over every simultaneous trigger.

Structure
REQ-034 Shared package SHALL hold state encoding, cause codes, K0 index 26, handler addresses 8000_0004/8000_0008.
REQ-035 Single module; no sub-modules; output ErrorTarget_o/ErrorTargetWrite connect directly to the error-target register.

Verification
REQ-036 undef=1, pc_i=32'h0000_0040 -> next cycle ErrorTargetWrite=1, ErrorTarget_o=26, epc_o=32'h0000_0044; then exc_pc_write=1, exc_pc_o=32'h8000_0008; cause_o=10.
REQ-037 irq pulse 1 cycle while boundary=0, later boundary=1, pc_i=32'h0000_0100 -> epc_o=32'h0000_0100, exc_pc_o=32'h8000_0004, irq_pend cleared.
REQ-038 irq=1 with pc_i=32'h8000_0010 and boundary=1 -> no pulses; later boundary with pc_i=32'h0000_0200 -> irq taken, epc 32'h0000_0200.
REQ-039 undef and pending irq same cycle at boundary -> undef taken first (cause 10), irq taken at next user boundary (cause 01), count=2.
REQ-040 reset asserted during SAVE -> next cycle all outputs 0, no exc_pc_write, count 0.
REQ-041 300 undef triggers -> exc_count_o stays 8'hFF.

Source files
------------

// File: rtl/exception_unit_pkg.sv
`default_nettype none
// ==========================================================================
// exception_unit_pkg : shared encodings for exception entry   (rev 1.0)
// ==========================================================================
package exception_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SAVE = 2'd1,
      ST_JUMP = 2'd2
   } state_t;

   localparam logic [1:0]  CAUSE_NONE    = 2'b00;
   localparam logic [1:0]  CAUSE_IRQ     = 2'b01;
   localparam logic [1:0]  CAUSE_UNDEF   = 2'b10;

   localparam logic [4:0]  K0_INDEX      = 5'd26;
   localparam logic [31:0] IRQ_HANDLER   = 32'h8000_0004;
   localparam logic [31:0] UNDEF_HANDLER = 32'h8000_0008;

   function automatic logic is_kernel(input logic [31:0] pc);
      return pc[31];
   endfunction

endpackage
`default_nettype wire

// File: rtl/exception_unit.sv
`default_nettype none
// ==========================================================================
// exception_unit : undef/irq exception entry sequencer (save EPC, load PC)
// rev 1.0
// ==========================================================================
module exception_unit
   import exception_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
   input  logic        boundary,
   input  logic        undef,
   input  logic [31:0] pc_i,
   output logic        ErrorTargetWrite,
   output logic [4:0]  ErrorTarget_o,
   output logic [31:0] epc_o,
   output logic        exc_pc_write,
   output logic [31:0] exc_pc_o,
   output logic        stall_o,
   output logic [1:0]  cause_o,
   output logic [7:0]  exc_count_o
);

   state_t      state;
   logic        irq_pend;
   logic [31:0] handler;

   logic        user_mode;
   logic        take_undef;
   logic        take_irq;
   logic [31:0] new_epc;
   logic [31:0] new_handler;
   logic [1:0]  new_cause;

   always_comb begin
      user_mode   = ~is_kernel(pc_i);
      take_undef  = (state == ST_IDLE) && undef && user_mode;
      take_irq    = (state == ST_IDLE) && boundary && irq_pend && user_mode && !take_undef;
      new_epc     = take_undef ? (pc_i + 32'd4) : pc_i;
      new_handler = take_undef ? UNDEF_HANDLER : IRQ_HANDLER;
      new_cause   = take_undef ? CAUSE_UNDEF : CAUSE_IRQ;
   end

   // epc_o doubles as the latched return address: it is only non-zero in SAVE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         irq_pend         <= 1'b0;
         handler          <= '0;
         cause_o          <= CAUSE_NONE;
         exc_count_o      <= '0;
         ErrorTargetWrite <= 1'b0;
         ErrorTarget_o    <= '0;
         epc_o            <= '0;
         exc_pc_write     <= 1'b0;
         exc_pc_o         <= '0;
         stall_o          <= 1'b0;
      end else begin
         // A still-asserted irq keeps the request pending even as one is taken.
         irq_pend <= (irq_pend & ~take_irq) | irq;
         case (state)
            ST_IDLE: begin
               if (take_undef || take_irq) begin
                  state            <= ST_SAVE;
                  handler          <= new_handler;
                  cause_o          <= new_cause;
                  if (exc_count_o != 8'hFF)
                     exc_count_o <= exc_count_o + 8'd1;
                  ErrorTargetWrite <= 1'b1;
                  ErrorTarget_o    <= K0_INDEX;
                  epc_o            <= new_epc;
                  stall_o          <= 1'b1;
               end
            end
            ST_SAVE: begin
               state            <= ST_JUMP;
               ErrorTargetWrite <= 1'b0;
               ErrorTarget_o    <= '0;
               epc_o            <= '0;
               exc_pc_write     <= 1'b1;
               exc_pc_o         <= handler;
               stall_o          <= 1'b1;
            end
            ST_JUMP: begin
               state        <= ST_IDLE;
               exc_pc_write <= 1'b0;
               exc_pc_o     <= '0;
               stall_o      <= 1'b0;
            end
            default: begin
               state            <= ST_IDLE;
               ErrorTargetWrite <= 1'b0;
               ErrorTarget_o    <= '0;
               epc_o            <= '0;
               exc_pc_write     <= 1'b0;
               exc_pc_o         <= '0;
               stall_o          <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exception_unit.sv
`default_nettype none
// ==========================================================================
// tb_exception_unit : directed + random scoreboard bench for exception_unit
// ==========================================================================
module tb_exception_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        irq = 1'b0;
   logic        boundary = 1'b0;
   logic        undef = 1'b0;
   logic [31:0] pc_i = '0;
   logic        ErrorTargetWrite;
   logic [4:0]  ErrorTarget_o;
   logic [31:0] epc_o;
   logic        exc_pc_write;
   logic [31:0] exc_pc_o;
   logic        stall_o;
   logic [1:0]  cause_o;
   logic [7:0]  exc_count_o;

   exception_unit dut (
      .clk(clk), .reset(reset), .irq(irq), .boundary(boundary), .undef(undef),
      .pc_i(pc_i), .ErrorTargetWrite(ErrorTargetWrite), .ErrorTarget_o(ErrorTarget_o),
      .epc_o(epc_o), .exc_pc_write(exc_pc_write), .exc_pc_o(exc_pc_o),
      .stall_o(stall_o), .cause_o(cause_o), .exc_count_o(exc_count_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic        etw;
      logic [4:0]  et;
      logic [31:0] epc;
      logic        pcw;
      logic [31:0] xpc;
      logic        stall;
      logic [1:0]  cause;
      logic [7:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: pending flag, remaining entry cycles, saturating count.
   bit          m_pend = 0;
   int          m_left = 0;
   logic [1:0]  m_cause = 0;
   int          m_count = 0;
   logic [31:0] m_ep = 0;
   logic [31:0] m_h = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("sched", cyc, e.cyc);
         chk("ErrorTargetWrite", {31'd0, ErrorTargetWrite}, {31'd0, e.etw});
         chk("ErrorTarget_o", {27'd0, ErrorTarget_o}, {27'd0, e.et});
         chk("epc_o", epc_o, e.epc);
         chk("exc_pc_write", {31'd0, exc_pc_write}, {31'd0, e.pcw});
         chk("exc_pc_o", exc_pc_o, e.xpc);
         chk("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
         chk("cause_o", {30'd0, cause_o}, {30'd0, e.cause});
         chk("exc_count_o", {24'd0, exc_count_o}, {24'd0, e.cnt});
      end
   end

   task automatic step(input logic r, input logic i, input logic b, input logic u,
                       input logic [31:0] p);
      exp_t e;
      bit   go;
      bit   took_irq;
      reset = r; irq = i; boundary = b; undef = u; pc_i = p;
      e = '{cyc: cyc + 1, etw: 1'b0, et: 5'd0, epc: 32'd0, pcw: 1'b0, xpc: 32'd0,
            stall: 1'b0, cause: 2'd0, cnt: 8'd0};
      go = 0;
      took_irq = 0;
      if (r) begin
         m_pend = 0; m_left = 0; m_cause = 0; m_count = 0;
      end else begin
         if (m_left == 0) begin
            if (u && !p[31]) begin
               m_ep = p + 32'd4; m_h = 32'h8000_0008; m_cause = 2'b10; go = 1;
            end else if (b && m_pend && !p[31]) begin
               m_ep = p; m_h = 32'h8000_0004; m_cause = 2'b01; go = 1; took_irq = 1;
            end
            if (go) begin
               m_count = (m_count < 255) ? m_count + 1 : 255;
               m_left = 2;
               e.etw = 1'b1; e.et = 5'd26; e.epc = m_ep; e.stall = 1'b1;
            end
         end else if (m_left == 2) begin
            m_left = 1;
            e.pcw = 1'b1; e.xpc = m_h; e.stall = 1'b1;
         end else begin
            m_left = 0;
         end
         m_pend = (m_pend && !took_irq) || i;
      end
      e.cause = m_cause;
      e.cnt = 8'(m_count);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [31:0] p);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, p);
   endtask

   initial begin
      logic [31:0] rnd;
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h0000_0040);    // reset beats simultaneous triggers
      idle(2, 32'h0000_0010);

      step(0, 0, 0, 1, 32'h0000_0040);    // undef at 0x40
      idle(4, 32'h0000_0044);

      step(0, 1, 0, 0, 32'h0000_00F0);    // irq pulse away from boundary
      idle(2, 32'h0000_00F4);
      step(0, 0, 1, 0, 32'h0000_0100);
      idle(4, 32'h0000_0104);

      step(0, 1, 1, 0, 32'h8000_0010);    // masked in kernel mode
      step(0, 0, 1, 0, 32'h8000_0010);
      step(0, 0, 1, 1, 32'h8000_0014);    // kernel undef ignored
      idle(2, 32'h8000_0018);
      step(0, 0, 1, 0, 32'h0000_0200);
      idle(4, 32'h0000_0204);

      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 32'h0000_0300);
      step(0, 0, 1, 1, 32'h0000_0304);    // undef wins over pending irq
      step(0, 0, 1, 0, 32'h0000_0304);
      idle(2, 32'h0000_0308);
      step(0, 0, 1, 0, 32'h0000_0400);
      idle(4, 32'h0000_0404);

      step(0, 0, 0, 1, 32'h7FFF_FFFC);    // epc wraps
      idle(4, 32'h0000_0000);

      step(0, 0, 0, 1, 32'h0000_0500);
      step(1, 0, 0, 0, 32'h0000_0504);    // reset lands while in SAVE
      idle(3, 32'h0000_0504);

      for (int k = 0; k < 300; k++) begin
         step(0, 0, 0, 1, 32'h0000_1000 + 32'(k * 4));
         idle(2, 32'h0000_1000);
      end
      idle(2, 32'h0000_2000);

      for (int k = 0; k < 2500; k++) begin
         rnd = $urandom();
         rnd[31] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) rnd = 32'h7FFF_FFFC;
         step($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, rnd);
      end
      idle(4, 32'h0000_0000);

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
